// File: rtl/mac_sequencer_if.sv
// Handshake and data bus between the MAC sequencer and the FP8 multiply-accumulate unit.
interface mac_sequencer_if;
    logic       MacDone;
    logic [7:0] MacAout;
    logic [7:0] MacAin;
    logic [7:0] MacB;
    logic [7:0] MacC;
    logic       MacReset;
    logic       MacLoad;

    modport master (
        input  MacDone, MacAout,
        output MacAin, MacB, MacC, MacReset, MacLoad
    );

    modport slave (
        output MacDone, MacAout,
        input  MacAin, MacB, MacC, MacReset, MacLoad
    );
endinterface

// File: rtl/mac_sequencer.sv
// Sequencer for the FP8 MAC: holds B/C operand pairs, seeds the accumulator, issues one Load
// per pair over the Load/Done handshake and captures the final accumulator, with a watchdog.
module mac_sequencer #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned AW      = 3,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 WrEn,
    input  logic [AW-1:0]        WrAddr,
    input  logic [7:0]           WrB,
    input  logic [7:0]           WrC,
    input  logic [AW:0]          Count,
    input  logic [7:0]           Init,
    input  logic                 Start,
    mac_sequencer_if.master      mac,
    output logic [7:0]           Result,
    output logic                 Busy,
    output logic                 Valid,
    output logic                 Error
);

    localparam int unsigned WdW     = $clog2(TIMEOUT + 1);
    localparam logic [WdW-1:0] WdOne  = {{(WdW-1){1'b0}}, 1'b1};
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);
    localparam logic [AW:0]    IdxOne = {{AW{1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        StIdle, StClr, StSettle, StIssue, StWaitLo, StWaitHi, StNext, StDone, StErr
    } state_e;

    state_e         state_q, state_d;
    logic [AW:0]    idx_q, idx_d;
    logic [AW:0]    count_q;
    logic [WdW-1:0] wd_q, wd_d;
    logic [7:0]     init_q, b_q, c_q;
    logic [7:0]     file_b [DEPTH];
    logic [7:0]     file_c [DEPTH];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wd_d    = wd_q;
        case (state_q)
            StIdle: begin
                if (Start) begin
                    idx_d   = '0;
                    state_d = StClr;
                end
            end
            StClr:    state_d = StSettle;
            StSettle: state_d = (count_q == '0) ? StDone : StIssue;
            StIssue: begin
                wd_d    = '0;
                state_d = StWaitLo;
            end
            StWaitLo: begin
                if (!mac.MacDone) begin
                    wd_d    = '0;
                    state_d = StWaitHi;
                end else begin
                    wd_d = wd_q + WdOne;
                    if (wd_q == WdLast) state_d = StErr;
                end
            end
            StWaitHi: begin
                if (mac.MacDone) begin
                    state_d = StNext;
                end else begin
                    wd_d = wd_q + WdOne;
                    if (wd_q == WdLast) state_d = StErr;
                end
            end
            StNext: begin
                // AW+1-bit compare so Count == DEPTH terminates without wrapping idx
                if (idx_q + IdxOne == count_q) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + IdxOne;
                    state_d = StIssue;
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            wd_q    <= '0;
            count_q <= '0;
            init_q  <= '0;
            b_q     <= '0;
            c_q     <= '0;
            Result  <= '0;
            Valid   <= 1'b0;
            Error   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wd_q    <= wd_d;
            if (state_q == StIdle && Start) begin
                count_q <= Count;
                init_q  <= Init;
                Valid   <= 1'b0;
                Error   <= 1'b0;
            end
            // Operands load on entry to ISSUE and stay put until the next pair
            if (state_d == StIssue) begin
                b_q <= file_b[idx_d[AW-1:0]];
                c_q <= file_c[idx_d[AW-1:0]];
            end
            if (state_q == StDone) begin
                Result <= mac.MacAout;
                Valid  <= 1'b1;
            end
            if (state_d == StErr) Error <= 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                file_b[i] <= '0;
                file_c[i] <= '0;
            end
        end else if (WrEn && !Busy) begin
            file_b[WrAddr] <= WrB;
            file_c[WrAddr] <= WrC;
        end
    end

    assign Busy         = !(state_q inside {StIdle, StErr});
    assign mac.MacAin   = init_q;
    assign mac.MacB     = b_q;
    assign mac.MacC     = c_q;
    assign mac.MacReset = (state_q == StClr);
    assign mac.MacLoad  = (state_q == StIssue);

endmodule
